// File: rtl/regbank_srx.sv
// Bank of NUM_REGS sticky status registers with masked write, 1-cycle addressed read,
// whole-bank shadow snapshot and per-register rising-event interrupts.
module regbank_srx #(
    parameter int              NUM_REGS  = 8,
    parameter int              WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int              AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      global_reset_n,
    input  logic                      wr_en,
    input  logic [AW-1:0]             wr_addr,
    input  logic [WIDTH-1:0]          wr_data,
    input  logic [WIDTH-1:0]          wr_mask,
    input  logic [NUM_REGS*WIDTH-1:0] set,
    input  logic [NUM_REGS*WIDTH-1:0] clr,
    input  logic                      rd_req,
    input  logic [AW-1:0]             rd_addr,
    input  logic                      rd_shadow,
    input  logic                      snap,
    input  logic [NUM_REGS-1:0]       irq_ack,
    output logic [NUM_REGS*WIDTH-1:0] out,
    output logic                      rd_valid,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      rd_err,
    output logic [NUM_REGS-1:0]       irq
);

    // Handshake: rd_req is accepted unconditionally every cycle; rd_valid pulses for
    // exactly one cycle, one cycle later, and there is no ready/stall path.

    logic [NUM_REGS-1:0][WIDTH-1:0] live_q;
    logic [NUM_REGS-1:0][WIDTH-1:0] shadow_q;
    logic [NUM_REGS-1:0][WIDTH-1:0] live_d;
    logic [NUM_REGS-1:0]            irq_d;
    logic [WIDTH-1:0]               wm;
    logic [WIDTH-1:0]               s_bits;
    logic [WIDTH-1:0]               c_bits;
    logic [WIDTH-1:0]               rd_sel;
    logic                           rd_hit;

    assign out = live_q;

    always_comb begin
        live_d = live_q;
        irq_d  = irq & ~irq_ack;
        rd_sel = '0;
        rd_hit = 1'b0;
        wm     = '0;
        s_bits = '0;
        c_bits = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            wm     = (wr_en && (wr_addr == AW'(r))) ? wr_mask : '0;
            s_bits = set[r*WIDTH +: WIDTH];
            c_bits = clr[r*WIDTH +: WIDTH];
            // Priority clr > set > write > hold, expressed bitwise.
            live_d[r] = (((live_q[r] & ~wm) | (wr_data & wm)) | s_bits) & ~c_bits;
            // Only set-driven 0->1 edges that survive clr raise the interrupt.
            if (|(s_bits & ~c_bits & ~live_q[r])) begin
                irq_d[r] = 1'b1;
            end
            if (rd_addr == AW'(r)) begin
                rd_hit = 1'b1;
                rd_sel = rd_shadow ? shadow_q[r] : live_q[r];
            end
        end
    end

    always_ff @(posedge clk or negedge global_reset_n) begin
        if (!global_reset_n) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                live_q[r]   <= RESET_VAL;
                shadow_q[r] <= RESET_VAL;
            end
            irq      <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            live_q <= live_d;
            irq    <= irq_d;
            if (snap) begin
                shadow_q <= live_q;
            end
            if (rd_req) begin
                rd_valid <= 1'b1;
                rd_data  <= rd_hit ? rd_sel : '0;
                rd_err   <= ~rd_hit;
            end else begin
                rd_valid <= 1'b0;
                rd_data  <= '0;
                rd_err   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regbank_srx.sv
// Directed bench for regbank_srx: an 8-register zero-reset bank driven from a vector
// table, plus a 6-register A5A5_0000-reset bank for reset and out-of-range reads.
module tb_regbank_srx;

    localparam int W = 32;

    logic            clk;
    logic            global_reset_n;
    logic            wr_en;
    logic [2:0]      wr_addr;
    logic [W-1:0]    wr_data;
    logic [W-1:0]    wr_mask;
    logic [8*W-1:0]  set;
    logic [8*W-1:0]  clr;
    logic            rd_req;
    logic [2:0]      rd_addr;
    logic            rd_shadow;
    logic            snap;
    logic [7:0]      irq_ack;
    logic [8*W-1:0]  out;
    logic            rd_valid;
    logic [W-1:0]    rd_data;
    logic            rd_err;
    logic [7:0]      irq;

    logic            wr_en_b;
    logic [6*W-1:0]  set_b;
    logic [6*W-1:0]  clr_b;
    logic            rd_req_b;
    logic            snap_b;
    logic [5:0]      irq_ack_b;
    logic [6*W-1:0]  out_b;
    logic            rd_valid_b;
    logic [W-1:0]    rd_data_b;
    logic            rd_err_b;
    logic [5:0]      irq_b;

    int n_checks = 0;
    int n_fail   = 0;

    regbank_srx #(.NUM_REGS(8), .WIDTH(W), .RESET_VAL(32'h0)) dut (
        .clk(clk), .global_reset_n(global_reset_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .set(set), .clr(clr),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_shadow(rd_shadow), .snap(snap),
        .irq_ack(irq_ack), .out(out),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err), .irq(irq)
    );

    regbank_srx #(.NUM_REGS(6), .WIDTH(W), .RESET_VAL(32'hA5A5_0000)) dut_b (
        .clk(clk), .global_reset_n(global_reset_n),
        .wr_en(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data), .wr_mask(wr_mask),
        .set(set_b), .clr(clr_b),
        .rd_req(rd_req_b), .rd_addr(rd_addr), .rd_shadow(rd_shadow), .snap(snap_b),
        .irq_ack(irq_ack_b), .out(out_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_err(rd_err_b), .irq(irq_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         wr_en;
        logic [2:0]   wr_addr;
        logic [W-1:0] wr_data;
        logic [W-1:0] wr_mask;
        int           set_reg;
        logic [W-1:0] set_v;
        logic [W-1:0] clr_v;
        logic         rd_req;
        logic [2:0]   rd_addr;
        logic         rd_shadow;
        logic         snap;
        logic [7:0]   ack;
        int           chk_reg;
        logic [W-1:0] exp_reg;
        logic [7:0]   exp_irq;
        logic         exp_valid;
        logic [W-1:0] exp_data;
        logic         exp_err;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(
        input logic we, input logic [2:0] wa, input logic [W-1:0] wd, input logic [W-1:0] wm,
        input int sr, input logic [W-1:0] sv, input logic [W-1:0] cv,
        input logic rq, input logic [2:0] ra, input logic rs, input logic sn, input logic [7:0] ak,
        input int cr, input logic [W-1:0] er, input logic [7:0] ei,
        input logic ev, input logic [W-1:0] ed, input logic ee);
        vec_t v;
        v.wr_en = we; v.wr_addr = wa; v.wr_data = wd; v.wr_mask = wm;
        v.set_reg = sr; v.set_v = sv; v.clr_v = cv;
        v.rd_req = rq; v.rd_addr = ra; v.rd_shadow = rs; v.snap = sn; v.ack = ak;
        v.chk_reg = cr; v.exp_reg = er; v.exp_irq = ei;
        v.exp_valid = ev; v.exp_data = ed; v.exp_err = ee;
        return v;
    endfunction

    // Driver tasks
    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        set = '0; clr = '0; rd_req = 1'b0; rd_addr = '0; rd_shadow = 1'b0;
        snap = 1'b0; irq_ack = '0;
        wr_en_b = 1'b0; set_b = '0; clr_b = '0; rd_req_b = 1'b0;
        snap_b = 1'b0; irq_ack_b = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [W-1:0] actual);
        logic [W-1:0] expected;
        expected = exp_q.pop_front();
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic check_wide(input string name, input logic [6*W-1:0] actual,
                              input logic [6*W-1:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    logic [6*W-1:0] b_reset_img;

    initial begin
        b_reset_img = {6{32'hA5A5_0000}};
        idle_inputs();
        global_reset_n = 1'b0;
        // A read held during reset must never produce a response.
        rd_req = 1'b1; rd_req_b = 1'b1; rd_addr = 3'd1;
        tick(); tick();

        check_wide("reset_out_b", out_b, b_reset_img);
        exp_q.push_back(32'(0)); check("reset_irq_b", 32'(irq_b));
        exp_q.push_back(32'(0)); check("reset_rd_valid_b", 32'(rd_valid_b));
        exp_q.push_back(32'(0)); check("reset_rd_valid", 32'(rd_valid));
        check_wide("reset_out_low", out[6*W-1:0], '0);

        @(negedge clk);
        global_reset_n = 1'b1;
        idle_inputs();
        tick(); tick();
        check_wide("post_release_out_b", out_b, b_reset_img);
        exp_q.push_back(32'(0)); check("post_release_irq_b", 32'(irq_b));
        exp_q.push_back(32'(0)); check("post_release_irq", 32'(irq));

        // Out-of-range read plus ignored out-of-range write on the 6-register bank.
        wr_en_b = 1'b1; wr_addr = 3'd6; wr_data = 32'hFFFF_FFFF; wr_mask = 32'hFFFF_FFFF;
        rd_req_b = 1'b1; rd_addr = 3'd7;
        tick();
        exp_q.push_back(32'(1)); check("oor_valid", 32'(rd_valid_b));
        exp_q.push_back(32'(1)); check("oor_err", 32'(rd_err_b));
        exp_q.push_back(32'h0);  check("oor_data", rd_data_b);
        check_wide("oor_write_ignored", out_b, b_reset_img);

        idle_inputs();
        rd_req_b = 1'b1; rd_addr = 3'd1;
        tick();
        exp_q.push_back(32'(1));          check("inrange_valid_b", 32'(rd_valid_b));
        exp_q.push_back(32'(0));          check("inrange_err_b", 32'(rd_err_b));
        exp_q.push_back(32'hA5A5_0000);   check("inrange_data_b", rd_data_b);

        idle_inputs();
        tick();
        exp_q.push_back(32'(0)); check("idle_valid_b", 32'(rd_valid_b));
        exp_q.push_back(32'h0);  check("idle_data_b", rd_data_b);
        exp_q.push_back(32'(0)); check("idle_err_b", 32'(rd_err_b));

        // Vector table for the 8-register bank (starts from all zeros).
        vecs[0]  = mk(1, 3, 32'hFFFF_FFFF, 32'h0000_FF00, 0, 0, 0,     1, 3, 0, 0, 8'h00, 3, 32'h0000_FF00, 8'h00, 1, 32'h0, 0);
        vecs[1]  = mk(0, 0, 0, 0,                         0, 0, 0,     1, 3, 0, 0, 8'h00, 3, 32'h0000_FF00, 8'h00, 1, 32'h0000_FF00, 0);
        vecs[2]  = mk(1, 2, 32'h0, 32'hF,                 2, 32'hF, 32'h3, 0, 0, 0, 0, 8'h00, 2, 32'hC, 8'h04, 0, 32'h0, 0);
        vecs[3]  = mk(0, 0, 0, 0,                         2, 32'h100, 0, 0, 0, 0, 0, 8'h04, 2, 32'h10C, 8'h04, 0, 32'h0, 0);
        vecs[4]  = mk(0, 0, 0, 0,                         0, 0, 0,     0, 0, 0, 0, 8'h04, 2, 32'h10C, 8'h00, 0, 32'h0, 0);
        vecs[5]  = mk(0, 0, 0, 0,                         2, 32'h4, 0, 0, 0, 0, 0, 8'h00, 2, 32'h10C, 8'h00, 0, 32'h0, 0);
        vecs[6]  = mk(1, 2, 32'h5, 32'hF,                 0, 0, 0,     0, 0, 0, 0, 8'h00, 2, 32'h105, 8'h00, 0, 32'h0, 0);
        vecs[7]  = mk(0, 0, 0, 0,                         2, 32'h10, 32'h10, 0, 0, 0, 0, 8'h00, 2, 32'h105, 8'h00, 0, 32'h0, 0);
        vecs[8]  = mk(1, 5, 32'h1234, 32'hFFFF_FFFF,      0, 0, 0,     0, 0, 0, 0, 8'h00, 5, 32'h1234, 8'h00, 0, 32'h0, 0);
        vecs[9]  = mk(1, 5, 32'h5678, 32'hFFFF_FFFF,      0, 0, 0,     1, 5, 1, 1, 8'h00, 5, 32'h5678, 8'h00, 1, 32'h0, 0);
        vecs[10] = mk(0, 0, 0, 0,                         0, 0, 0,     1, 5, 1, 0, 8'h00, 5, 32'h5678, 8'h00, 1, 32'h1234, 0);
        vecs[11] = mk(0, 0, 0, 0,                         0, 0, 0,     1, 5, 0, 0, 8'h00, 5, 32'h5678, 8'h00, 1, 32'h5678, 0);
        vecs[12] = mk(1, 2, 32'h0, 32'hFFFF_FFFF,         0, 0, 0,     1, 2, 0, 0, 8'h00, 2, 32'h0, 8'h00, 1, 32'h105, 0);
        vecs[13] = mk(0, 0, 0, 0,                         7, 32'h8000_0000, 0, 0, 0, 0, 0, 8'h04, 7, 32'h8000_0000, 8'h80, 0, 32'h0, 0);
        vecs[14] = mk(0, 0, 0, 0,                         7, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 8'h80, 7, 32'h0, 8'h00, 0, 32'h0, 0);

        for (int i = 0; i < 15; i++) begin
            idle_inputs();
            wr_en = vecs[i].wr_en; wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data; wr_mask = vecs[i].wr_mask;
            set[vecs[i].set_reg*W +: W] = vecs[i].set_v;
            clr[vecs[i].set_reg*W +: W] = vecs[i].clr_v;
            rd_req = vecs[i].rd_req; rd_addr = vecs[i].rd_addr;
            rd_shadow = vecs[i].rd_shadow; snap = vecs[i].snap; irq_ack = vecs[i].ack;
            tick();
            exp_q.push_back(vecs[i].exp_reg);       check($sformatf("v%0d_reg", i), out[vecs[i].chk_reg*W +: W]);
            exp_q.push_back(32'(vecs[i].exp_irq));  check($sformatf("v%0d_irq", i), 32'(irq));
            exp_q.push_back(32'(vecs[i].exp_valid)); check($sformatf("v%0d_rd_valid", i), 32'(rd_valid));
            exp_q.push_back(vecs[i].exp_data);      check($sformatf("v%0d_rd_data", i), rd_data);
            exp_q.push_back(32'(vecs[i].exp_err));  check($sformatf("v%0d_rd_err", i), 32'(rd_err));
        end

        // Reset asserted mid-cycle after a read request: the response is dropped.
        idle_inputs();
        rd_req = 1'b1; rd_req_b = 1'b1; rd_addr = 3'd5;
        @(negedge clk);
        global_reset_n = 1'b0;
        tick();
        exp_q.push_back(32'(0)); check("abort_rd_valid", 32'(rd_valid));
        exp_q.push_back(32'(0)); check("abort_rd_valid_b", 32'(rd_valid_b));
        exp_q.push_back(32'h0);  check("abort_reg5_reset", out[5*W +: W]);
        idle_inputs();
        @(negedge clk);
        global_reset_n = 1'b1;
        tick();
        exp_q.push_back(32'(0)); check("abort_after_release", 32'(rd_valid));
        check_wide("abort_out_b", out_b, b_reset_img);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
